// File: rtl/router_pkg.sv
// Shared definitions for the 1xN packet router control path: legal port
// counts, the controller state encoding and the address-width helper.
package router_pkg;

  // Legal range for the number of output FIFOs behind one router.
  localparam int MIN_PORTS = 2;
  localparam int MAX_PORTS = 16;

  // Controller state codes. Codes 9..15 are unused and recover to decode.
  localparam logic [3:0] ST_DECODE_ADDRESS     = 4'd0;
  localparam logic [3:0] ST_WAIT_TILL_EMPTY    = 4'd1;
  localparam logic [3:0] ST_LOAD_FIRST_DATA    = 4'd2;
  localparam logic [3:0] ST_LOAD_DATA          = 4'd3;
  localparam logic [3:0] ST_FIFO_FULL_STATE    = 4'd4;
  localparam logic [3:0] ST_LOAD_AFTER_FULL    = 4'd5;
  localparam logic [3:0] ST_LOAD_PARITY        = 4'd6;
  localparam logic [3:0] ST_CHECK_PARITY_ERROR = 4'd7;
  localparam logic [3:0] ST_DROP_PACKET        = 4'd8;

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = ST_DECODE_ADDRESS,
    WAIT_TILL_EMPTY    = ST_WAIT_TILL_EMPTY,
    LOAD_FIRST_DATA    = ST_LOAD_FIRST_DATA,
    LOAD_DATA          = ST_LOAD_DATA,
    FIFO_FULL_STATE    = ST_FIFO_FULL_STATE,
    LOAD_AFTER_FULL    = ST_LOAD_AFTER_FULL,
    LOAD_PARITY        = ST_LOAD_PARITY,
    CHECK_PARITY_ERROR = ST_CHECK_PARITY_ERROR,
    DROP_PACKET        = ST_DROP_PACKET
  } state_t;

  // Header address field width; a 2-port router still needs one bit.
  function automatic int addr_width(input int ports);
    return (ports <= 2) ? 1 : $clog2(ports);
  endfunction

endpackage

// File: rtl/router_ctrl_fsm.sv
// Packet-router control FSM for a 1xN router. Decodes the header address,
// waits for a busy destination to drain, sequences header/payload/parity
// loads into the selected FIFO, discards packets addressed to a port that
// does not exist and aborts a packet when its destination is soft-reset.
//
// Handshake: pkt_valid qualifies data_in and every byte; there is no ready
// path back to the source. A byte is taken on every rising edge where
// pkt_valid is high and the FSM is in a load or drop state; busy=1 tells the
// source the controller cannot take a new byte this cycle. pkt_valid low
// while loading marks the parity byte.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int  NUM_PORTS  = 3,
  parameter int  DROP_CNT_W = 8,
  localparam int ADDR_W     = addr_width(NUM_PORTS)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  pkt_valid,
  input  logic [ADDR_W-1:0]     data_in,
  input  logic                  fifo_full,
  input  logic [NUM_PORTS-1:0]  fifo_empty,
  input  logic [NUM_PORTS-1:0]  soft_reset,
  input  logic                  parity_done,
  input  logic                  low_pkt_valid,
  output logic                  detect_add,
  output logic                  lfd_state,
  output logic                  ld_state,
  output logic                  laf_state,
  output logic                  full_state,
  output logic                  write_enb_reg,
  output logic                  rst_int_reg,
  output logic                  busy,
  output logic                  drop_state,
  output logic [ADDR_W-1:0]     dest_addr,
  output logic                  dest_valid,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  if (NUM_PORTS < MIN_PORTS || NUM_PORTS > MAX_PORTS) begin : g_bad_ports
    $error("router_ctrl_fsm: NUM_PORTS out of range");
  end

  state_t state_q;
  state_t state_d;

  logic addr_invalid;
  logic hdr_accept;
  logic hdr_drop;
  logic soft_abort;

  assign addr_invalid = (int'(data_in) >= NUM_PORTS);
  assign hdr_accept   = (state_q == DECODE_ADDRESS) && pkt_valid && !addr_invalid;
  assign hdr_drop     = (state_q == DECODE_ADDRESS) && pkt_valid && addr_invalid;

  // A soft reset only matters for the port currently holding a live packet.
  assign soft_abort = soft_reset[dest_addr] && dest_valid &&
                      (state_q != DECODE_ADDRESS) && (state_q != DROP_PACKET);

  // Next-state rules for the packet sequence.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        if (pkt_valid) begin
          if (addr_invalid)             state_d = DROP_PACKET;
          else if (fifo_empty[data_in]) state_d = LOAD_FIRST_DATA;
          else                          state_d = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (fifo_empty[dest_addr]) state_d = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       state_d = FIFO_FULL_STATE;
        else if (!pkt_valid) state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) state_d = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        state_d = DECODE_ADDRESS;
        else if (low_pkt_valid) state_d = LOAD_PARITY;
        else                    state_d = LOAD_DATA;
      end
      LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (fifo_full) state_d = FIFO_FULL_STATE;
        else           state_d = DECODE_ADDRESS;
      end
      DROP_PACKET: begin
        if (!pkt_valid) state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
  end

  // State register; a destination soft reset overrides the normal sequence.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           state_q <= DECODE_ADDRESS;
    else if (soft_abort) state_q <= DECODE_ADDRESS;
    else                 state_q <= state_d;
  end

  // Destination latch; dest_valid is dropped on abort or a clean packet end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dest_addr  <= '0;
      dest_valid <= 1'b0;
    end else if (soft_abort) begin
      dest_valid <= 1'b0;
    end else if (hdr_accept) begin
      dest_addr  <= data_in;
      dest_valid <= 1'b1;
    end else if ((state_q == CHECK_PARITY_ERROR) && !fifo_full) begin
      dest_valid <= 1'b0;
    end
  end

  // Saturating count of packets discarded for an out-of-range address.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                          drop_cnt <= '0;
    else if (hdr_drop && !(&drop_cnt))  drop_cnt <= drop_cnt + DROP_CNT_W'(1);
  end

  // Moore decodes of the state register.
  assign detect_add    = (state_q == DECODE_ADDRESS);
  assign lfd_state     = (state_q == LOAD_FIRST_DATA);
  assign ld_state      = (state_q == LOAD_DATA);
  assign laf_state     = (state_q == LOAD_AFTER_FULL);
  assign full_state    = (state_q == FIFO_FULL_STATE);
  assign drop_state    = (state_q == DROP_PACKET);
  assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
  assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_AFTER_FULL) ||
                         (state_q == LOAD_PARITY);
  assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA) ||
                           (state_q == DROP_PACKET));

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Bench for router_ctrl_fsm with NUM_PORTS=3 and a 2-bit drop counter.
module tb_router_ctrl_fsm;

  localparam int NP = 3;
  localparam int DW = 2;
  localparam int AW = 2;

  // Decode vectors: {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy, drop}
  localparam logic [8:0] V_DEC  = 9'b100000000;
  localparam logic [8:0] V_WTE  = 9'b000000010;
  localparam logic [8:0] V_LFD  = 9'b010000010;
  localparam logic [8:0] V_LD   = 9'b001001000;
  localparam logic [8:0] V_FULL = 9'b000010010;
  localparam logic [8:0] V_LAF  = 9'b000101010;
  localparam logic [8:0] V_LP   = 9'b000001010;
  localparam logic [8:0] V_CPE  = 9'b000000110;
  localparam logic [8:0] V_DROP = 9'b000000001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic          pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [AW-1:0] data_in;
  logic [NP-1:0] fifo_empty, soft_reset;
  logic detect_add, lfd_state, ld_state, laf_state, full_state;
  logic write_enb_reg, rst_int_reg, busy, drop_state, dest_valid;
  logic [AW-1:0] dest_addr;
  logic [DW-1:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  router_ctrl_fsm #(.NUM_PORTS(NP), .DROP_CNT_W(DW)) dut (
    .clk(clk), .rstn(rstn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_state(drop_state),
    .dest_addr(dest_addr), .dest_valid(dest_valid), .drop_cnt(drop_cnt)
  );

  function automatic logic [8:0] obs_vec();
    return {detect_add, lfd_state, ld_state, laf_state, full_state,
            write_enb_reg, rst_int_reg, busy, drop_state};
  endfunction

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_WAIT = 1, P_FIRST = 2, P_BODY = 3, P_FULL = 4,
                 P_AFTER = 5, P_PAR = 6, P_CHK = 7, P_DROP = 8;
  int            m_phase;
  logic [AW-1:0] m_dest;
  logic          m_dv;
  int            m_drop;

  function automatic logic [8:0] phase_vec(input int p);
    case (p)
      P_WAIT:  return V_WTE;
      P_FIRST: return V_LFD;
      P_BODY:  return V_LD;
      P_FULL:  return V_FULL;
      P_AFTER: return V_LAF;
      P_PAR:   return V_LP;
      P_CHK:   return V_CPE;
      P_DROP:  return V_DROP;
      default: return V_DEC;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_dest  = '0;
    m_dv    = 1'b0;
    m_drop  = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (m_phase != P_IDLE && m_phase != P_DROP && m_dv && soft_reset[m_dest]) begin
      m_phase = P_IDLE;
      m_dv    = 1'b0;
      return;
    end
    case (m_phase)
      P_IDLE: if (pkt_valid) begin
        if (int'(data_in) >= NP) begin
          m_phase = P_DROP;
          if (m_drop < (1 << DW) - 1) m_drop++;
        end else begin
          m_dest  = data_in;
          m_dv    = 1'b1;
          m_phase = fifo_empty[data_in] ? P_FIRST : P_WAIT;
        end
      end
      P_WAIT:  if (fifo_empty[m_dest]) m_phase = P_FIRST;
      P_FIRST: m_phase = P_BODY;
      P_BODY:  if (fifo_full) m_phase = P_FULL; else if (!pkt_valid) m_phase = P_PAR;
      P_FULL:  if (!fifo_full) m_phase = P_AFTER;
      P_AFTER: if (parity_done) m_phase = P_IDLE;
               else if (low_pkt_valid) m_phase = P_PAR;
               else m_phase = P_BODY;
      P_PAR:   m_phase = P_CHK;
      P_CHK:   if (fifo_full) m_phase = P_FULL;
               else begin m_phase = P_IDLE; m_dv = 1'b0; end
      P_DROP:  if (!pkt_valid) m_phase = P_IDLE;
      default: m_phase = P_IDLE;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pkt_valid = 1'b0; data_in = '0; fifo_full = 1'b0; fifo_empty = '1;
    soft_reset = '0; parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rstn = 1'b0;
    model_reset();
    #3;
    total++; if (obs_vec() !== V_DEC) begin bad++; $display("FAIL reset_decodes got=%b want=%b", obs_vec(), V_DEC); end
    total++; if (dest_addr !== '0) begin bad++; $display("FAIL reset_dest_addr got=%0d want=0", dest_addr); end
    total++; if (dest_valid !== 1'b0) begin bad++; $display("FAIL reset_dest_valid got=%b want=0", dest_valid); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_basic_packet();
    logic [8:0] exp_seq [0:8];
    exp_seq = '{V_DEC, V_LFD, V_LD, V_LD, V_LD, V_LD, V_LP, V_CPE, V_DEC};
    drive_idle();
    data_in = 2'd1;
    for (int i = 0; i < 9; i++) begin
      pkt_valid = (i <= 4);
      total++;
      if (obs_vec() !== exp_seq[i]) begin
        bad++; $display("FAIL basic_seq[%0d] got=%b want=%b", i, obs_vec(), exp_seq[i]);
      end
      if (i < 8) tick();
    end
    total++; if (dest_addr !== 2'd1) begin bad++; $display("FAIL basic_dest_addr got=%0d want=1", dest_addr); end
    total++; if (dest_valid !== 1'b0) begin bad++; $display("FAIL basic_dest_valid_end got=%b want=0", dest_valid); end
  endtask

  task automatic test_wait_empty();
    drive_idle();
    pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
    tick();
    for (int k = 0; k < 5; k++) begin
      total++;
      if (obs_vec() !== V_WTE) begin bad++; $display("FAIL wait_hold[%0d] got=%b want=%b", k, obs_vec(), V_WTE); end
      if (k < 4) tick();
    end
    fifo_empty = 3'b111;
    tick();
    total++; if (obs_vec() !== V_LFD) begin bad++; $display("FAIL wait_release got=%b want=%b", obs_vec(), V_LFD); end
    tick();
    pkt_valid = 1'b0;
    tick(); tick(); tick();
    total++; if (obs_vec() !== V_DEC) begin bad++; $display("FAIL wait_end got=%b want=%b", obs_vec(), V_DEC); end
    total++; if (dest_addr !== 2'd2) begin bad++; $display("FAIL wait_dest_addr got=%0d want=2", dest_addr); end
  endtask

  // Inputs per cycle: {pkt_valid, fifo_full, low_pkt_valid, parity_done}
  task automatic test_fifo_full(input logic use_pd);
    logic [3:0] in_t  [0:9];
    logic [8:0] exp_t [0:9];
    int n;
    int full_cycles;
    in_t  = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1000,
              (use_pd ? 4'b0001 : 4'b0010), 4'b0000, 4'b0000, 4'b0000};
    if (use_pd) exp_t = '{V_DEC, V_LFD, V_LD, V_FULL, V_FULL, V_FULL, V_LAF, V_DEC, V_DEC, V_DEC};
    else        exp_t = '{V_DEC, V_LFD, V_LD, V_FULL, V_FULL, V_FULL, V_LAF, V_LP, V_CPE, V_DEC};
    n = use_pd ? 8 : 10;
    full_cycles = 0;
    drive_idle();
    data_in = 2'd0;
    for (int i = 0; i < n; i++) begin
      {pkt_valid, fifo_full, low_pkt_valid, parity_done} = in_t[i];
      if (full_state === 1'b1) full_cycles++;
      total++;
      if (obs_vec() !== exp_t[i]) begin
        bad++; $display("FAIL full_seq_pd%0d[%0d] got=%b want=%b", use_pd, i, obs_vec(), exp_t[i]);
      end
      if (i < n - 1) tick();
    end
    total++; if (full_cycles != 3) begin bad++; $display("FAIL full_cycle_count got=%0d want=3", full_cycles); end
  endtask

  task automatic test_drop();
    drive_idle();
    pkt_valid = 1'b1; data_in = 2'd3;
    tick();
    for (int k = 0; k < 3; k++) begin
      total++;
      if (obs_vec() !== V_DROP || write_enb_reg !== 1'b0) begin
        bad++; $display("FAIL drop_hold[%0d] got=%b want=%b", k, obs_vec(), V_DROP);
      end
      if (k == 2) pkt_valid = 1'b0;
      tick();
    end
    total++; if (obs_vec() !== V_DEC) begin bad++; $display("FAIL drop_exit got=%b want=%b", obs_vec(), V_DEC); end
    total++; if (drop_cnt !== 2'd1) begin bad++; $display("FAIL drop_cnt_first got=%0d want=1", drop_cnt); end
    for (int k = 2; k <= 5; k++) begin
      pkt_valid = 1'b1; data_in = 2'd3;
      tick();
      pkt_valid = 1'b0;
      tick();
      total++;
      if (drop_cnt !== DW'((k > 3) ? 3 : k)) begin
        bad++; $display("FAIL drop_cnt_sat[%0d] got=%0d want=%0d", k, drop_cnt, (k > 3) ? 3 : k);
      end
    end
  endtask

  task automatic test_soft_reset();
    drive_idle();
    pkt_valid = 1'b1; data_in = 2'd0;
    tick(); tick();
    soft_reset = 3'b010;
    tick();
    total++; if (obs_vec() !== V_LD || dest_valid !== 1'b1) begin
      bad++; $display("FAIL soft_other_port got=%b dv=%b want=%b dv=1", obs_vec(), dest_valid, V_LD); end
    soft_reset = 3'b001;
    tick();
    total++; if (obs_vec() !== V_DEC || dest_valid !== 1'b0) begin
      bad++; $display("FAIL soft_own_port got=%b dv=%b want=%b dv=0", obs_vec(), dest_valid, V_DEC); end
    soft_reset = '0; pkt_valid = 1'b0;
    tick();
    total++; if (obs_vec() !== V_DEC) begin bad++; $display("FAIL soft_after got=%b want=%b", obs_vec(), V_DEC); end
  endtask

  task automatic test_async_reset();
    drive_idle();
    pkt_valid = 1'b1; data_in = 2'd1;
    tick(); tick();
    fifo_full = 1'b1;
    tick();
    total++; if (obs_vec() !== V_FULL) begin bad++; $display("FAIL areset_pre got=%b want=%b", obs_vec(), V_FULL); end
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    total++; if (obs_vec() !== V_DEC || busy !== 1'b0) begin
      bad++; $display("FAIL areset_decodes got=%b want=%b", obs_vec(), V_DEC); end
    total++; if (dest_addr !== '0 || dest_valid !== 1'b0) begin
      bad++; $display("FAIL areset_dest got=%0d/%b want=0/0", dest_addr, dest_valid); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL areset_drop_cnt got=%0d want=0", drop_cnt); end
    drive_idle();
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = AW'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty    = NP'($urandom_range(0, 7));
      soft_reset    = ($urandom_range(0, 15) == 0) ? NP'($urandom_range(1, 7)) : '0;
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 1) == 1);
      tick();
      total++;
      if (obs_vec() !== phase_vec(m_phase)) begin
        bad++; $display("FAIL rand_decodes[%0d] got=%b want=%b", c, obs_vec(), phase_vec(m_phase)); end
      total++;
      if (dest_addr !== m_dest || dest_valid !== m_dv) begin
        bad++; $display("FAIL rand_dest[%0d] got=%0d/%b want=%0d/%b", c, dest_addr, dest_valid, m_dest, m_dv); end
      total++;
      if (drop_cnt !== DW'(m_drop)) begin
        bad++; $display("FAIL rand_drop_cnt[%0d] got=%0d want=%0d", c, drop_cnt, m_drop); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_packet();
    test_wait_empty();
    test_fifo_full(1'b0);
    test_fifo_full(1'b1);
    test_drop();
    test_soft_reset();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Parametrised packet-router control FSM for a 1xN router. It sits between the register block and the per-port synchroniser/FIFO bank, and decodes each header's destination address. It sequences header, payload and parity loads into the selected output FIFO, and adds three things the 3-port controller lacks:
- a real wait-till-empty on a busy destination;
- discard of packets with an invalid address;
- per-port soft-reset abort.

## Interface
Parameters:
- NUM_PORTS, 3, number of output FIFOs (2..16)
- ADDR_W, $clog2(NUM_PORTS) (min 1), header address field width; derived localparam, not overridable
- DROP_CNT_W, 8, width of the saturating dropped-packet counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- pkt_valid  in  1  source asserts for header+payload bytes, deasserts on parity byte
- data_in  in  ADDR_W  address field of current header byte, sampled only in DECODE_ADDRESS
- fifo_full  in  1  full flag of the currently selected FIFO
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags
- soft_reset  in  NUM_PORTS  per-FIFO read-timeout soft resets
- parity_done  in  1  register block has captured parity
- low_pkt_valid  in  1  register block: pkt_valid fell while FIFO full
- detect_add, lfd_state, ld_state, laf_state, full_state, write_enb_reg, rst_int_reg, busy, drop_state  out  1 each  Moore state decodes
- dest_addr  out  ADDR_W  latched destination
- dest_valid  out  1  dest_addr holds a live packet's destination
- drop_cnt  out  DROP_CNT_W  count of discarded packets, saturating

## Operation
- States: DECODE_ADDRESS, WAIT_TILL_EMPTY, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, DROP_PACKET.
- DECODE_ADDRESS:
  - pkt_valid & data_in>=NUM_PORTS -> DROP_PACKET; drop_cnt += 1, saturating at all-ones.
  - pkt_valid & fifo_empty[data_in] -> LOAD_FIRST_DATA.
  - pkt_valid & !fifo_empty[data_in] -> WAIT_TILL_EMPTY.
  - Else stay.
- dest_addr<=data_in and dest_valid<=1 on any valid-address pkt_valid in DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty[dest_addr] -> LOAD_FIRST_DATA, else stay.
- LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
- LOAD_DATA:
  - fifo_full -> FIFO_FULL_STATE.
  - Else !pkt_valid -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL:
  - parity_done -> DECODE_ADDRESS.
  - Else low_pkt_valid -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR:
  - fifo_full -> FIFO_FULL_STATE.
  - Else -> DECODE_ADDRESS, clearing dest_valid.
- DROP_PACKET: !pkt_valid -> DECODE_ADDRESS. Bytes are accepted but never written.
- Output decodes:
  - detect_add=DECODE_ADDRESS.
  - lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE.
  - drop_state=DROP_PACKET, rst_int_reg=CHECK_PARITY_ERROR.
  - write_enb_reg in LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY only. LOAD_FIRST_DATA writes via lfd_state.
  - busy=0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET; 1 elsewhere.
- Soft reset:
  - Trigger: soft_reset[dest_addr] & dest_valid, in any state other than DECODE_ADDRESS/DROP_PACKET.
  - Effect: state<=DECODE_ADDRESS, dest_valid<=0 at next edge.
  - soft_reset bits for non-selected ports are ignored.
- Priority: rstn > soft reset > next-state logic.

## Timing
- All outputs are Moore: driven combinationally from the state register and registered dest_addr/dest_valid/drop_cnt. No input-to-output combinational path.
- Reset (rstn=0, async):
  - State is DECODE_ADDRESS, so detect_add=1 and every other state decode is 0.
  - busy=0, dest_addr=0, dest_valid=0, drop_cnt=0.
- Header accepted in cycle T with an empty destination: lfd_state=1 at T+1, ld_state=1 at T+2.
- Parity byte (pkt_valid low) in LOAD_DATA at cycle T: LOAD_PARITY at T+1, CHECK_PARITY_ERROR at T+2, DECODE_ADDRESS at T+3.
- fifo_full and pkt_valid both high in LOAD_DATA: full wins.
- fifo_empty[dest_addr] rising in WAIT_TILL_EMPTY at T: LOAD_FIRST_DATA at T+1.
- rstn asserted mid-packet: immediate return to reset values. No partial-state retention.

## Structure
- Shared package router_pkg holds:
  - the state encoding: 4-bit enum, localparams for all 9 states;
  - the NUM_PORTS limits.
- Single module, no sub-module. drop_cnt is inline saturating logic.
- Two-process FSM (state register, next-state) plus separate registers for dest_addr, dest_valid, drop_cnt.

## Test plan
- NUM_PORTS=3, address 1, fifo_empty=3'b111, 4 payload bytes then parity:
  - visit order DECODE, LFD, LD x4, LP, CPE, DECODE;
  - busy high in LFD/LP/CPE;
  - dest_addr=1.
- Address 2 with fifo_empty[2]=0 for 5 cycles: stays in WAIT_TILL_EMPTY with busy=1; LFD the cycle after fifo_empty[2] rises.
- fifo_full high for 3 cycles mid-payload:
  - full_state asserted 3 cycles, then LAF;
  - low_pkt_valid=1 -> LP;
  - second run with parity_done=1 -> DECODE.
- Address 3 with NUM_PORTS=3: drop_state held until pkt_valid falls, write_enb_reg never set, drop_cnt=1. With DROP_CNT_W=2, 5 drops -> drop_cnt=3.
- soft_reset[0] pulsed during LOAD_DATA with dest_addr=0: DECODE next cycle, dest_valid=0. soft_reset[1] in the same situation: no effect.
- rstn low in FIFO_FULL_STATE: all outputs at reset values without a clock edge.
